// File: rtl/data_mem_unit_pkg.sv
// Shared types and constants for the data memory unit.
package dmem_pkg;

    localparam int LANE_W = 8;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_WORD,
        SZ_HALF,
        SZ_BYTE
    } size_e;

    // Byte access wins over halfword; neither flag means a full word.
    function automatic size_e decode_size(input logic byte_op, input logic half_op);
        if (byte_op) begin
            return SZ_BYTE;
        end
        if (half_op) begin
            return SZ_HALF;
        end
        return SZ_WORD;
    endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Request/response bus between the memory stage and the data memory.
interface data_mem_unit_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              mem_write;
    logic              byte_op;
    logic              half_op;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              rsp_valid;
    logic [WORD_W-1:0] read_data;
    logic              rsp_error;

    modport master (
        output req_valid, mem_write, byte_op, half_op, addr, wdata,
        input  req_ready, rsp_valid, read_data, rsp_error
    );

    modport slave (
        input  req_valid, mem_write, byte_op, half_op, addr, wdata,
        output req_ready, rsp_valid, read_data, rsp_error
    );

endinterface

// File: rtl/data_mem_unit_lane_align.sv
// Byte-lane steering: write enables/data for stores, alignment and
// zero-fill for loads, and the misalignment flag.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_e              size,
    input  logic [1:0]         addr_lo,
    input  logic [WORD_W-1:0]  wdata,
    input  logic [WORD_W-1:0]  raw_word,
    output logic [3:0]         byte_en,
    output logic [WORD_W-1:0]  wdata_rep,
    output logic               misalign,
    output logic [WORD_W-1:0]  rdata_aligned
);

    logic [WORD_W-1:0] byte_shift;

    assign byte_shift = raw_word >> {addr_lo, 3'b000};

    // Lane selection and data steering per access size.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        byte_en       = 4'b1111;
        wdata_rep     = wdata;
        misalign      = 1'b0;
        rdata_aligned = raw_word;
        case (size)
            SZ_BYTE: begin
                byte_en       = 4'b0001 << addr_lo;
                wdata_rep     = {4{wdata[LANE_W-1:0]}};
                rdata_aligned = {24'h0, byte_shift[LANE_W-1:0]};
            end
            SZ_HALF: begin
                byte_en       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep     = {2{wdata[15:0]}};
                misalign      = addr_lo[0];
                rdata_aligned = {16'h0, (addr_lo[1] ? raw_word[31:16] : raw_word[15:0])};
            end
            default: begin
                misalign = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// Single-port word-organised data memory with a fixed access latency,
// one outstanding request, and registered aligned load data.
module data_mem_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
)
(
    input  logic            clk,
    input  logic            rst_n,
    data_mem_unit_if.slave  bus
);

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    size_e             size_q, size_d;
    logic [WORD_W-1:0] read_data_q, read_data_d;
    logic              rsp_error_q, rsp_error_d;

    logic [WORD_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  word_idx;
    logic [WORD_W-1:0] raw_word;
    logic [3:0]        byte_en;
    logic [WORD_W-1:0] wdata_rep;
    logic              misalign;
    logic [WORD_W-1:0] rdata_aligned;
    logic              out_of_range;
    logic              access_err;
    logic              commit;
    logic              mem_we;

    assign word_idx     = addr_q[IDX_W+1:2];
    assign raw_word     = mem[word_idx];
    assign out_of_range = (addr_q[31:2] >= 30'(DEPTH));
    assign access_err   = misalign | out_of_range;
    assign mem_we       = commit & write_q & ~access_err;

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.read_data = read_data_q;
    assign bus.rsp_error = rsp_error_q;

    dmem_lane_align u_align (
        .size          (size_q),
        .addr_lo       (addr_q[1:0]),
        .wdata         (wdata_q),
        .raw_word      (raw_word),
        .byte_en       (byte_en),
        .wdata_rep     (wdata_rep),
        .misalign      (misalign),
        .rdata_aligned (rdata_aligned)
    );

    // Next-state, request latch, wait counter and response capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        size_d      = size_q;
        read_data_d = read_data_q;
        rsp_error_d = rsp_error_q;
        commit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_INIT;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    write_d = bus.mem_write;
                    size_d  = decode_size(bus.byte_op, bus.half_op);
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    commit      = 1'b1;
                    rsp_error_d = access_err;
                    read_data_d = (access_err || write_q) ? '0 : rdata_aligned;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            size_q      <= SZ_WORD;
            read_data_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            size_q      <= size_d;
            read_data_q <= read_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // Byte-enabled array write; a reset on the commit edge drops the store.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; only the control path is.
        if (rst_n && mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[word_idx][k*LANE_W +: LANE_W] <= wdata_rep[k*LANE_W +: LANE_W];
                end
            end
        end
    end

endmodule
